// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one imem transaction at a time and hands
// {inst, pc} to IF/ID over valid/ready. Redirects drop any stale in-flight fetch.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        arst_n,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [63:0] if_pc_o,
  input  logic        id_ready_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] drain_addr_q, drain_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [63:0] redirect_tgt;

  assign redirect_tgt = redirect_pc_i & ~64'h3;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks every other event
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (redirect_valid_i) begin
          state_d = imem_rvalid_i ? StFetch : StDrain;
        end else if (imem_rvalid_i) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (redirect_valid_i || id_ready_i) state_d = StFetch;
      end
      StDrain: begin
        if (imem_rvalid_i) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req_o  = (state_q == StFetch) || (state_q == StDrain);
    imem_addr_o = (state_q == StDrain) ? drain_addr_q : pc_q;
  end

  // Datapath next-state
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    inst_d       = inst_q;
    if_pc_d      = if_pc_q;
    unique case (state_q)
      StFetch: begin
        if (redirect_valid_i) begin
          pc_d = redirect_tgt;
          if (!imem_rvalid_i) drain_addr_d = pc_q;
        end else if (imem_rvalid_i) begin
          valid_d = 1'b1;
          inst_d  = imem_rdata_i;
          if_pc_d = pc_q;
        end
      end
      StHold: begin
        if (redirect_valid_i) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          pc_d    = redirect_tgt;
        end else if (id_ready_i) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          pc_d    = pc_q + 64'd4;
        end
      end
      StDrain: begin
        if (redirect_valid_i) pc_d = redirect_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      valid_q      <= 1'b0;
      inst_q       <= NOP_INST;
      if_pc_q      <= RESET_PC;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      if_pc_q      <= if_pc_d;
    end
  end

  assign if_valid_o = valid_q;
  assign if_inst_o  = inst_q;
  assign if_pc_o    = if_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected imem completions and IF/ID handoffs are
// queued by the stimulus and checked by independent monitors; stall/redirect state is spot-checked.
module tb_if_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        arst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [63:0] exp_addr_q[$];
  logic [95:0] exp_out_q[$];

  if_fetch_unit dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .if_valid_o       (if_valid),
    .if_inst_o        (if_inst),
    .if_pc_o          (if_pc),
    .id_ready_i       (id_ready),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc)
  );

  // Memory model: word at address A is 0x00A00093 + A
  assign imem_rdata = imem_addr[31:0] + 32'h00A0_0093;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    if (arst_n && imem_req && imem_rvalid) begin
      if (exp_addr_q.size() == 0) chk("unexpected_imem_completion", {32'h0, imem_addr}, 96'hx);
      else chk("imem_addr", {32'h0, imem_addr}, {32'h0, exp_addr_q.pop_front()});
    end
  end

  // IF/ID consumption monitor
  always @(negedge clk) begin
    if (arst_n && if_valid && id_ready && !redirect_valid) begin
      if (exp_out_q.size() == 0) chk("unexpected_consume", {if_inst, if_pc}, 96'hx);
      else chk("if_inst_pc", {if_inst, if_pc}, exp_out_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_req"},   {95'h0, imem_req}, 96'h0);
    chk({tag, "_addr"},  {32'h0, imem_addr}, 96'h0);
    chk({tag, "_valid"}, {95'h0, if_valid}, 96'h0);
    chk({tag, "_inst"},  {64'h0, if_inst}, {64'h0, Nop});
    chk({tag, "_pc"},    {32'h0, if_pc}, 96'h0);
  endtask

  initial begin
    arst_n = 1'b0;
    imem_rvalid = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    step(2);
    chk_reset_outs("rst");

    // T1: rvalid tied high, back-to-back fetches 0x0, 0x4, 0x8
    #3 arst_n = 1'b1;
    #1 chk("t1_req_low_cycle1", {95'h0, imem_req}, 96'h0);
    imem_rvalid = 1'b1;
    id_ready = 1'b1;
    exp_addr_q.push_back(64'h0);
    exp_addr_q.push_back(64'h4);
    exp_addr_q.push_back(64'h8);
    exp_out_q.push_back({32'h00A0_0093, 64'h0});
    exp_out_q.push_back({32'h00A0_0097, 64'h4});
    exp_out_q.push_back({32'h00A0_009B, 64'h8});
    step(1);
    chk("t1_req_cycle2", {95'h0, imem_req}, 96'h1);
    step(1);
    chk("t1_valid_after_completion", {95'h0, if_valid}, 96'h1);
    step(5);

    // T2: stall in HOLD for 5 cycles
    imem_rvalid = 1'b1;
    id_ready = 1'b0;
    exp_addr_q.push_back(64'hC);
    step(1);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_state", {imem_req, if_valid, if_inst, if_pc},
          {1'b0, 1'b1, 32'h00A0_009F, 64'hC});
      step(1);
    end
    id_ready = 1'b1;
    exp_out_q.push_back({32'h00A0_009F, 64'hC});
    step(1);
    id_ready = 1'b0;
    chk("t2_next_addr", {32'h0, imem_addr}, {32'h0, 64'h10});

    // T3: redirect while fetch outstanding -> drain old address first
    exp_addr_q.push_back(64'h10);
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    step(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_drain_addr_held", {imem_req, imem_addr}, {1'b1, 64'h10});
      if (i == 2) imem_rvalid = 1'b1;
      step(1);
    end
    imem_rvalid = 1'b0;
    chk("t3_new_target", {if_valid, imem_req, imem_addr}, {1'b0, 1'b1, 64'h100});

    // T4: redirect coincides with completion in FETCH
    exp_addr_q.push_back(64'h100);
    imem_rvalid = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h203;
    step(1);
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_dropped", {if_valid, if_inst, imem_addr}, {1'b0, Nop, 64'h200});

    // T5: redirect in HOLD beats id_ready
    exp_addr_q.push_back(64'h200);
    imem_rvalid = 1'b1;
    step(1);
    imem_rvalid = 1'b0;
    chk("t5_hold", {if_valid, if_inst, if_pc}, {1'b1, 32'h00A0_0293, 64'h200});
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h400;
    step(1);
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("t5_not_consumed", {if_valid, if_inst, imem_addr}, {1'b0, Nop, 64'h400});

    // T6: async reset during DRAIN
    redirect_valid = 1'b1;
    redirect_pc = 64'h500;
    step(1);
    redirect_valid = 1'b0;
    chk("t6_in_drain", {imem_req, imem_addr}, {1'b1, 64'h400});
    #2 arst_n = 1'b0;
    #1 chk_reset_outs("t6_async");
    step(1);
    #3 arst_n = 1'b1;
    imem_rvalid = 1'b1;
    id_ready = 1'b1;
    exp_addr_q.push_back(64'h0);
    exp_out_q.push_back({32'h00A0_0093, 64'h0});
    step(1);
    chk("t6_restart", {imem_req, imem_addr}, {1'b1, 64'h0});
    step(1);
    imem_rvalid = 1'b0;
    step(1);
    id_ready = 1'b0;
    chk("t6_pc_advance", {imem_req, imem_addr}, {1'b1, 64'h4});

    step(2);
    chk("addr_queue_drained", {64'h0, 32'(exp_addr_q.size())}, 96'h0);
    chk("out_queue_drained", {64'h0, 32'(exp_out_q.size())}, 96'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
